// File: rtl/endian_stream_converter.sv
// Endian stream converter: per-beat byte-lane swap followed by a 2-deep
// registered pipeline (output register plus skid register) with ready/valid handshakes.
module endian_stream_converter #(
    parameter int unsigned BYTE_SIZE   = 8,
    parameter int unsigned INPUT_BYTES = 4,
    parameter int unsigned COUNT_WIDTH = 16
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              in_valid,
    output logic                              in_ready,
    input  logic [INPUT_BYTES*BYTE_SIZE-1:0]  in_data,
    input  logic [1:0]                        in_mode,
    input  logic                              in_last,
    output logic                              out_valid,
    input  logic                              out_ready,
    output logic [INPUT_BYTES*BYTE_SIZE-1:0]  out_data,
    output logic                              out_last,
    output logic [COUNT_WIDTH-1:0]            beat_count,
    output logic                              busy
);

    localparam int unsigned Width = INPUT_BYTES * BYTE_SIZE;

    logic [Width-1:0]       swapped;
    logic                   in_fire;
    logic                   out_fire;

    logic                   out_valid_q;
    logic [Width-1:0]       out_data_q;
    logic                   out_last_q;
    logic                   skid_valid_q;
    logic [Width-1:0]       skid_data_q;
    logic                   skid_last_q;
    logic [COUNT_WIDTH-1:0] count_q;

    // Lane remap happens before the registers so out_data is always a flop output.
    always_comb begin
        int unsigned src;
        swapped = '0;
        src     = 0;
        for (int unsigned i = 0; i < INPUT_BYTES; i++) begin
            case (in_mode)
                2'd0:    src = i;
                2'd1:    src = INPUT_BYTES - 1 - i;
                2'd2:    src = i ^ 1;
                default: src = (i + INPUT_BYTES / 2) % INPUT_BYTES;
            endcase
            swapped[i*BYTE_SIZE +: BYTE_SIZE] = in_data[src*BYTE_SIZE +: BYTE_SIZE];
        end
    end

    assign in_ready = ~skid_valid_q;
    assign in_fire  = in_valid & in_ready;
    assign out_fire = out_valid_q & out_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid_q  <= 1'b0;
            out_data_q   <= '0;
            out_last_q   <= 1'b0;
            skid_valid_q <= 1'b0;
            skid_data_q  <= '0;
            skid_last_q  <= 1'b0;
        end else if (out_fire) begin
            // in_ready is low whenever the skid is full, so no accept can collide here.
            if (skid_valid_q) begin
                out_data_q   <= skid_data_q;
                out_last_q   <= skid_last_q;
                skid_valid_q <= 1'b0;
            end else if (in_fire) begin
                out_data_q <= swapped;
                out_last_q <= in_last;
            end else begin
                out_valid_q <= 1'b0;
            end
        end else if (in_fire) begin
            if (!out_valid_q) begin
                out_valid_q <= 1'b1;
                out_data_q  <= swapped;
                out_last_q  <= in_last;
            end else begin
                skid_valid_q <= 1'b1;
                skid_data_q  <= swapped;
                skid_last_q  <= in_last;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= '0;
        end else if (out_fire && (count_q != '1)) begin
            count_q <= count_q + 1'b1;
        end
    end

    assign out_valid  = out_valid_q;
    assign out_data   = out_data_q;
    assign out_last   = out_last_q;
    assign beat_count = count_q;
    assign busy       = out_valid_q | skid_valid_q;

endmodule
